// File: rtl/cc_bus_sequencer_if.sv
// rtl/cc_bus_sequencer_if.sv - instruction/bus-mux handshake bundle for cc_bus_sequencer
// master drives instructions and hold; slave is the sequencer itself.
interface cc_bus_sequencer_if #(
  parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
  parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6,
  parameter int DATAWIDTH_COUNT                 = 4
);
  localparam int INSTR_W = 1 + DATAWIDTH_MUX_SELECTION_CONTROL
                             + DATAWIDTH_MUX_SELECTION_REG + DATAWIDTH_COUNT;

  logic [INSTR_W-1:0]                         CC_SEQ_instr_InBUS;
  logic                                       CC_SEQ_instrValid_In;
  logic                                       CC_SEQ_instrReady_Out;
  logic                                       CC_SEQ_hold_In;
  logic                                       CC_SEQ_selector_Out;
  logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_SEQ_control_OutBUS;
  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_SEQ_registro_OutBUS;
  logic                                       CC_SEQ_strobe_Out;
  logic                                       CC_SEQ_done_Out;
  logic                                       CC_SEQ_error_Out;

  modport master (
    output CC_SEQ_instr_InBUS, CC_SEQ_instrValid_In, CC_SEQ_hold_In,
    input  CC_SEQ_instrReady_Out, CC_SEQ_selector_Out, CC_SEQ_control_OutBUS,
           CC_SEQ_registro_OutBUS, CC_SEQ_strobe_Out, CC_SEQ_done_Out, CC_SEQ_error_Out
  );

  modport slave (
    input  CC_SEQ_instr_InBUS, CC_SEQ_instrValid_In, CC_SEQ_hold_In,
    output CC_SEQ_instrReady_Out, CC_SEQ_selector_Out, CC_SEQ_control_OutBUS,
           CC_SEQ_registro_OutBUS, CC_SEQ_strobe_Out, CC_SEQ_done_Out, CC_SEQ_error_Out
  );
endinterface

// File: rtl/cc_bus_sequencer.sv
// rtl/cc_bus_sequencer.sv - issues count+1 bus-mux beats per captured instruction
// Optional code range check enabled by defining CC_BUS_SEQUENCER_RANGECHECK_EN.
module cc_bus_sequencer #(
  parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
  parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6,
  parameter int DATAWIDTH_COUNT                 = 4
) (
  input logic           CC_SEQ_CLOCK_50,
  input logic           CC_SEQ_RESET_InHigh,
  cc_bus_sequencer_if.slave bus
);
  localparam int REG_W   = DATAWIDTH_MUX_SELECTION_REG;
  localparam int CTRL_W  = DATAWIDTH_MUX_SELECTION_CONTROL;
  localparam int CNT_W   = DATAWIDTH_COUNT;
  localparam int INSTR_W = 1 + CTRL_W + REG_W + CNT_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state, state_next;
  logic                src_q;
  logic [CTRL_W-1:0]   control_q;
  logic [REG_W-1:0]    registro_q;
  logic [CNT_W-1:0]    count_q;

  logic                src_in;
  logic [CTRL_W-1:0]   control_in, control_cap;
  logic [REG_W-1:0]    registro_in, registro_cap;
  logic [CNT_W-1:0]    count_in;
  logic                capture, beat;

  assign src_in      = bus.CC_SEQ_instr_InBUS[INSTR_W-1];
  assign control_in  = bus.CC_SEQ_instr_InBUS[INSTR_W-2 -: CTRL_W];
  assign registro_in = bus.CC_SEQ_instr_InBUS[REG_W+CNT_W-1 -: REG_W];
  assign count_in    = bus.CC_SEQ_instr_InBUS[CNT_W-1:0];

  assign capture = (state == IDLE) && bus.CC_SEQ_instrValid_In;
  assign beat    = (state == ISSUE) && !bus.CC_SEQ_hold_In;

`ifdef CC_BUS_SEQUENCER_RANGECHECK_EN
  logic ctrl_bad, reg_bad, error_q;

  // Only the code selected by src is range-checked; an offending code is zeroed.
  assign ctrl_bad     = !src_in && (32'(control_in) > 32'd11);
  assign reg_bad      =  src_in && (32'(registro_in) > 32'd11);
  assign control_cap  = ctrl_bad ? '0 : control_in;
  assign registro_cap = reg_bad  ? '0 : registro_in;

  always_ff @(posedge CC_SEQ_CLOCK_50) begin
    if (CC_SEQ_RESET_InHigh) begin
      error_q <= 1'b0;
    end else if (capture && (ctrl_bad || reg_bad)) begin
      error_q <= 1'b1;
    end
  end

  assign bus.CC_SEQ_error_Out = error_q;
`else
  assign control_cap  = control_in;
  assign registro_cap = registro_in;
  assign bus.CC_SEQ_error_Out = 1'b0;
`endif

  always_ff @(posedge CC_SEQ_CLOCK_50) begin
    if (CC_SEQ_RESET_InHigh) begin
      state      <= IDLE;
      src_q      <= 1'b0;
      control_q  <= '0;
      registro_q <= '0;
      count_q    <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        src_q      <= src_in;
        control_q  <= control_cap;
        registro_q <= registro_cap;
        count_q    <= count_in;
      end else if (beat && (count_q != '0)) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.CC_SEQ_instrValid_In) state_next = ISSUE;
      ISSUE:   if (beat && (count_q == '0)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are masked while reset is asserted so an aborted burst emits nothing more.
  assign bus.CC_SEQ_instrReady_Out  = (state == IDLE) && !CC_SEQ_RESET_InHigh;
  assign bus.CC_SEQ_strobe_Out      = beat && !CC_SEQ_RESET_InHigh;
  assign bus.CC_SEQ_done_Out        = (state == DONE) && !CC_SEQ_RESET_InHigh;
  assign bus.CC_SEQ_selector_Out    = src_q;
  assign bus.CC_SEQ_control_OutBUS  = control_q;
  assign bus.CC_SEQ_registro_OutBUS = registro_q;
endmodule

// File: tb/tb_cc_bus_sequencer.sv
// tb/tb_cc_bus_sequencer.sv - randomized self-checking bench for cc_bus_sequencer
// Expected per-cycle behaviour comes from a beat-counting transaction model.
module tb_cc_bus_sequencer;
  localparam int R = 5;
  localparam int C = 6;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_bus_sequencer_if #(.DATAWIDTH_MUX_SELECTION_REG(R), .DATAWIDTH_MUX_SELECTION_CONTROL(C),
                        .DATAWIDTH_COUNT(N)) bus ();

  cc_bus_sequencer #(.DATAWIDTH_MUX_SELECTION_REG(R), .DATAWIDTH_MUX_SELECTION_CONTROL(C),
                     .DATAWIDTH_COUNT(N)) dut (
    .CC_SEQ_CLOCK_50    (clk),
    .CC_SEQ_RESET_InHigh(rst),
    .bus                (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       exp_sel;
  logic [5:0] exp_ctrl;
  logic [4:0] exp_reg;
  logic       exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic rdy, input logic stb, input logic dn);
    chk({tag, ".ready"},    32'(bus.CC_SEQ_instrReady_Out),  32'(rdy));
    chk({tag, ".strobe"},   32'(bus.CC_SEQ_strobe_Out),      32'(stb));
    chk({tag, ".done"},     32'(bus.CC_SEQ_done_Out),        32'(dn));
    chk({tag, ".selector"}, 32'(bus.CC_SEQ_selector_Out),    32'(exp_sel));
    chk({tag, ".control"},  32'(bus.CC_SEQ_control_OutBUS),  32'(exp_ctrl));
    chk({tag, ".registro"}, 32'(bus.CC_SEQ_registro_OutBUS), 32'(exp_reg));
    chk({tag, ".error"},    32'(bus.CC_SEQ_error_Out),       32'(exp_err));
  endtask

  // Model of what a captured word should present on the mux outputs.
  task automatic model_capture(input logic [15:0] w);
    exp_sel  = w[15];
    exp_ctrl = w[14:9];
    exp_reg  = w[8:4];
`ifdef CC_BUS_SEQUENCER_RANGECHECK_EN
    if (!exp_sel && exp_ctrl > 6'd11) begin exp_ctrl = '0; exp_err = 1'b1; end
    if ( exp_sel && exp_reg  > 5'd11) begin exp_reg  = '0; exp_err = 1'b1; end
`endif
  endtask

  task automatic model_reset();
    exp_sel = 1'b0; exp_ctrl = '0; exp_reg = '0; exp_err = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.CC_SEQ_instrValid_In = 1'b1;
    bus.CC_SEQ_hold_In       = 1'b0;
    @(negedge clk);
    check_cycle({tag, ".in_reset"}, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.CC_SEQ_instrValid_In = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      bus.CC_SEQ_hold_In = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_cycle({tag, ".after_reset"}, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // hold_mode: 0 never, 1 random, 2 two cycles right after the second beat.
  // abort_after > 0 resets the DUT once that many beats have been issued.
  task automatic run_instr(input string tag, input logic [15:0] w, input int hold_mode,
                           input int abort_after);
    int n     = int'(w[3:0]) + 1;
    int beats = 0;
    int held  = 0;
    int cyc   = 0;
    logic h;
    bus.CC_SEQ_instr_InBUS   = w;
    bus.CC_SEQ_instrValid_In = 1'b1;
    bus.CC_SEQ_hold_In       = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_cycle({tag, ".idle"}, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    model_capture(w);
    while (beats < n) begin
      // Foreign words presented while busy must be ignored.
      bus.CC_SEQ_instr_InBUS   = 16'($urandom);
      bus.CC_SEQ_instrValid_In = 1'($urandom_range(0, 1));
      case (hold_mode)
        1:       h = ($urandom_range(0, 2) == 0);
        2:       h = (beats == 2) && (held < 2);
        default: h = 1'b0;
      endcase
      if (h) held++;
      bus.CC_SEQ_hold_In = h;
      @(negedge clk);
      check_cycle({tag, ".issue"}, 1'b0, !h, 1'b0);
      @(posedge clk); #1;
      if (!h) beats++;
      cyc++;
      if (abort_after > 0 && beats == abort_after) begin
        do_reset({tag, ".abort"});
        return;
      end
      if (cyc > 200) begin
        chk({tag, ".cycle_budget"}, 32'(cyc), 32'd200);
        return;
      end
    end
    bus.CC_SEQ_instr_InBUS   = 16'($urandom);
    bus.CC_SEQ_instrValid_In = 1'($urandom_range(0, 1));
    bus.CC_SEQ_hold_In       = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_cycle({tag, ".done"}, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.CC_SEQ_instrValid_In = 1'b0;
    bus.CC_SEQ_hold_In       = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_cycle({tag, ".ready"}, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.CC_SEQ_instr_InBUS   = '0;
    bus.CC_SEQ_instrValid_In = 1'b0;
    bus.CC_SEQ_hold_In       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_cycle("reset", 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    run_instr("single_beat", 16'h0290, 0, 0);
    run_instr("four_beats", 16'h80B3, 0, 0);
    run_instr("four_beats_hold", 16'h80B3, 2, 0);
    run_instr("abort", 16'h80B3, 0, 2);
    run_instr("ctrl12", {1'b0, 6'd12, 5'd3, 4'd2}, 0, 0);
    run_instr("err_sticky", 16'h0290, 1, 0);
    run_instr("reg_max", {1'b1, 6'd40, 5'd31, 4'd15}, 1, 0);
    for (int i = 0; i < 25; i++) begin
      run_instr("random", 16'($urandom), 1, 0);
    end
    run_instr("random_abort", 16'($urandom) | 16'h000F, 1, 5);
    run_instr("final", 16'h80B3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_bus_sequencer.md
CC_BUS_SEQUENCER -- requirements
Module: cc_bus_sequencer

Interface
REQ-001 Parameter DATAWIDTH_MUX_SELECTION_REG, default 5: width of the register-select code.
REQ-002 Parameter DATAWIDTH_MUX_SELECTION_CONTROL, default 6: width of the control-select code.
REQ-003 Parameter DATAWIDTH_COUNT, default 4: width of the beat-repeat field.
REQ-004 CC_SEQ_CLOCK_50  input  1: single clock; all state updates on the rising edge.
REQ-005 CC_SEQ_RESET_InHigh  input  1: reset, synchronous and active-high.
REQ-006 CC_SEQ_instr_InBUS  input  1+CTRL+REG+COUNT (16 at defaults): {src[15], control[14:9], registro[8:4], count[3:0]}.
REQ-007 CC_SEQ_instrValid_In  input  1: instruction word valid.
REQ-008 CC_SEQ_instrReady_Out  output  1: sequencer can accept an instruction.
REQ-009 CC_SEQ_hold_In  input  1: downstream bus-mux consumer stall.
REQ-010 CC_SEQ_selector_Out  output  1: mux source select (0 = control code, 1 = register code).
REQ-011 CC_SEQ_control_OutBUS  output  CTRL: control-select code to the bus mux.
REQ-012 CC_SEQ_registro_OutBUS  output  REG: register-select code to the bus mux.
REQ-013 CC_SEQ_strobe_Out  output  1: one bus beat is issued this cycle.
REQ-014 CC_SEQ_done_Out  output  1: one-cycle pulse, instruction complete.
REQ-015 CC_SEQ_error_Out  output  1: sticky range-violation flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, DONE; encoding free.
REQ-017 IDLE: instrReady=1; on instrValid=1 capture src/control/registro/count into internal registers and go to ISSUE next cycle; else stay.
REQ-018 instrReady SHALL be 1 only in IDLE; instructions presented outside IDLE are ignored and not captured.
REQ-019 selector/control/registro outputs SHALL drive the captured values from the cycle after capture until the next capture, stable across hold.
REQ-020 ISSUE with hold=0: strobe=1; if beat counter==0 go to DONE, else decrement counter and stay.
REQ-021 ISSUE with hold=1: strobe=0, counter unchanged, state unchanged.
REQ-022 Beats per instruction SHALL be count+1 (1..16); count=0 gives exactly one strobe.
REQ-023 DONE: done=1 for exactly one cycle, strobe=0, then IDLE.
REQ-024 Latency: capture at edge N -> first strobe in cycle N+1 if hold=0; done in cycle after last strobe; ready in the cycle after done.
REQ-025 hold in IDLE or DONE SHALL have no effect.
REQ-026 Counter SHALL never wrap; decrement is not performed at 0.

Reset
REQ-027 On reset: state=IDLE, instrReady=1 after reset release, strobe=0, done=0, selector=0, control=0, registro=0, counter=0, error=0.
REQ-028 Reset mid-ISSUE SHALL abort the instruction with no further strobe and no done pulse.
REQ-029 Reset SHALL take priority over instrValid and hold in the same cycle.

Configuration
REQ-030 Macro CC_BUS_SEQUENCER_RANGECHECK_EN defined: at capture, src=0 with control>11 or src=1 with registro>11 sets error=1 (sticky until reset); the instruction still executes with the offending code replaced by 0.
REQ-031 Macro undefined: error tied to 0; codes pass through unchecked.

Verification
REQ-032 Reset, then instr=0x0290 (src0, control 1, reg 9, count 0), hold=0 -> selector=0, control=1, one strobe in cycle N+1, done in N+2, ready in N+3.
REQ-033 instr=0x80B3 (src1, reg 11, count 3), hold=0 -> selector=1, registro=11, four consecutive strobes, then one done.
REQ-034 Same as REQ-033 with hold=1 for 2 cycles after second strobe -> strobe gaps of 2 cycles, total still 4 strobes, outputs stable.
REQ-035 Reset asserted after 2nd of 4 strobes -> no further strobe, no done, all outputs at reset values, ready=1 after release.
REQ-036 RANGECHECK_EN defined, instr src0 control=12 -> error=1 persists, control output=0, 1+count strobes issued; undefined build -> error=0, control=12.
REQ-037 instrValid held high during ISSUE with different word -> ignored; next capture only in IDLE.
